// File: rtl/rom_dump_pkg.sv
// rtl/rom_dump_pkg.sv - shared types and widths for the ROM dump UART
package rom_dump_pkg;

    localparam int ROM_ADDR_W      = 9;
    localparam int ROM_DATA_W      = 8;
    localparam int UART_FRAME_BITS = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_DATA,
        S_STOP
    } dump_state_t;

endpackage

// File: rtl/uart_baud_timer.sv
// rtl/uart_baud_timer.sv - bit-period timer, bit_end marks the last cycle of each bit
module uart_baud_timer #(
    parameter int BAUD_DIV = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_end
);

    localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

    if (BAUD_DIV < 2) begin : g_bad_baud
        $error("uart_baud_timer: BAUD_DIV must be at least 2");
    end

    logic [CNT_W-1:0] r_cnt;

    assign bit_end = (r_cnt == CNT_W'(BAUD_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (restart || bit_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rom_dump_uart.sv
// rtl/rom_dump_uart.sv - streams a ROM address window out as 8N1 UART frames
module rom_dump_uart
    import rom_dump_pkg::*;
#(
    parameter int BAUD_DIV   = 868,
    parameter int START_ADDR = 0,
    parameter int END_ADDR   = 511
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [ROM_DATA_W-1:0] rom_data,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    if (START_ADDR < 0 || START_ADDR > END_ADDR || END_ADDR > 511) begin : g_bad_window
        $error("rom_dump_uart: need 0 <= START_ADDR <= END_ADDR <= 511");
    end

    localparam logic [ROM_ADDR_W-1:0] START_A  = ROM_ADDR_W'(START_ADDR);
    localparam logic [ROM_ADDR_W-1:0] END_A    = ROM_ADDR_W'(END_ADDR);
    localparam logic [2:0]            LAST_BIT = 3'(UART_FRAME_BITS - 3);

    dump_state_t           r_state;
    logic [ROM_DATA_W-1:0] r_shift;
    logic [2:0]            r_bit_idx;
    logic                  r_abort;
    logic                  w_bit_end;
    logic                  w_restart;

    // Holding the timer cleared through IDLE and FETCH makes START begin at count 0.
    assign w_restart = (r_state == S_IDLE) || (r_state == S_FETCH);

    uart_baud_timer #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (w_restart),
        .bit_end (w_bit_end)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            rom_addr  <= START_A;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_abort   <= 1'b0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy && abort) begin
                r_abort <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_FETCH;
                        busy    <= 1'b1;
                    end
                end
                S_FETCH: begin
                    r_shift <= rom_data;
                    tx      <= 1'b0;
                    r_state <= S_START;
                end
                S_START: begin
                    if (w_bit_end) begin
                        tx        <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == LAST_BIT) begin
                            tx      <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            tx        <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        // End-address test comes first so the last byte always completes and never wraps.
                        if (rom_addr == END_A || r_abort) begin
                            done     <= (rom_addr == END_A);
                            busy     <= 1'b0;
                            r_abort  <= 1'b0;
                            rom_addr <= START_A;
                            r_state  <= S_IDLE;
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                            r_state  <= S_FETCH;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_dump_uart.sv
// tb/tb_rom_dump_uart.sv - scoreboard bench for rom_dump_uart over four address windows
module tb_rom_dump_uart;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] rst_v;
    logic [3:0] start_v;
    logic [3:0] abort_v;
    logic [8:0] addr_v [4];
    logic [7:0] data_v [4];
    logic [3:0] tx_v;
    logic [3:0] busy_v;
    logic [3:0] done_v;

    logic [7:0] rom [512];
    logic [7:0] exp_q [4][$];

    int n_checks = 0;
    int n_errors = 0;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            data_v[k] = rom[addr_v[k]];
        end
    end

    rom_dump_uart #(.BAUD_DIV(4), .START_ADDR(0), .END_ADDR(3)) u_win (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .abort(abort_v[0]),
        .rom_addr(addr_v[0]), .rom_data(data_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));

    rom_dump_uart #(.BAUD_DIV(4), .START_ADDR(5), .END_ADDR(5)) u_single (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .abort(abort_v[1]),
        .rom_addr(addr_v[1]), .rom_data(data_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));

    rom_dump_uart #(.BAUD_DIV(4), .START_ADDR(510), .END_ADDR(511)) u_top (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .abort(abort_v[2]),
        .rom_addr(addr_v[2]), .rom_data(data_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    rom_dump_uart #(.BAUD_DIV(2), .START_ADDR(0), .END_ADDR(511)) u_full (
        .clk(clk), .rst(rst_v[3]), .start(start_v[3]), .abort(abort_v[3]),
        .rom_addr(addr_v[3]), .rom_data(data_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // UART receivers: frames disturbed by a reset are dropped, the rest are popped and compared.
    for (genvar g = 0; g < 4; g++) begin : g_mon
        localparam int B = (g == 3) ? 2 : 4;
        initial begin
            logic [7:0] b;
            logic       sb;
            bit         lost;
            forever begin
                @(negedge clk);
                if (rst_v[g] === 1'b1 && tx_v[g] === 1'b0) begin
                    lost = 1'b0;
                    repeat (B / 2) @(negedge clk);
                    if (!rst_v[g]) lost = 1'b1;
                    for (int j = 0; j < 8; j++) begin
                        repeat (B) @(negedge clk);
                        if (!rst_v[g]) lost = 1'b1;
                        b[j] = tx_v[g];
                    end
                    repeat (B) @(negedge clk);
                    if (!rst_v[g]) lost = 1'b1;
                    sb = tx_v[g];
                    if (!lost) begin
                        check($sformatf("stop_bit[%0d]", g), 32'(sb), 32'd1);
                        if (exp_q[g].size() == 0) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL rx_unexpected[%0d]: got 0x%0h, expected no frame", g, b);
                        end else begin
                            check($sformatf("rx_byte[%0d]", g), 32'(b), 32'(exp_q[g].pop_front()));
                        end
                    end
                end
            end
        end
    end

    task automatic pulse_start(input int k);
        @(posedge clk);
        #1 start_v[k] = 1'b1;
        @(posedge clk);
        #1 start_v[k] = 1'b0;
    endtask

    task automatic run_until(input int k, input bit want_done, input int max_cyc,
                             output int cyc, output int mx, output int mn, output int first_low);
        cyc = 0; mx = 0; mn = 511; first_low = -1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (int'(addr_v[k]) > mx) mx = int'(addr_v[k]);
            if (int'(addr_v[k]) < mn) mn = int'(addr_v[k]);
            if (first_low < 0 && tx_v[k] == 1'b0) first_low = cyc;
            if (want_done ? done_v[k] : !busy_v[k]) break;
            if (cyc >= max_cyc) break;
        end
    endtask

    initial begin
        int cyc, mx, mn, fl, cnt, low_cnt;
        for (int i = 0; i < 512; i++) rom[i] = 8'($urandom);
        rom[0] = 8'h0F; rom[1] = 8'h22; rom[2] = 8'h33; rom[3] = 8'h44;
        rom[5] = 8'hA5; rom[510] = 8'h3C; rom[511] = 8'hC3;
        rst_v = '0; start_v = '0; abort_v = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", 32'(tx_v), 32'hF);
        check("rst_busy", 32'(busy_v), 32'h0);
        check("rst_done", 32'(done_v), 32'h0);
        check("rst_addr_single", 32'(addr_v[1]), 32'h005);
        check("rst_addr_top", 32'(addr_v[2]), 32'h1FE);
        rst_v = 4'hF;

        // Single byte 0xA5 at BAUD_DIV=4
        exp_q[1].push_back(8'hA5);
        pulse_start(1);
        check("sb_busy_after_start", 32'(busy_v[1]), 32'd1);
        check("sb_tx_in_fetch", 32'(tx_v[1]), 32'd1);
        run_until(1, 1'b1, 200, cyc, mx, mn, fl);
        check("sb_done_latency", 32'(cyc), 32'd41);
        check("sb_tx_fall_cycle", 32'(fl), 32'd1);
        check("sb_busy_at_done", 32'(busy_v[1]), 32'd0);
        @(posedge clk);
        #1;
        check("sb_done_width", 32'(done_v[1]), 32'd0);

        // Top-of-ROM window 0x1FE..0x1FF
        exp_q[2].push_back(8'h3C);
        exp_q[2].push_back(8'hC3);
        pulse_start(2);
        run_until(2, 1'b1, 400, cyc, mx, mn, fl);
        check("top_done_latency", 32'(cyc), 32'd82);
        check("top_max_addr", 32'(mx), 32'h1FF);
        check("top_min_addr", 32'(mn), 32'h1FE);
        cnt = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (done_v[2]) cnt++;
            if (addr_v[2] == 9'h000) cnt++;
        end
        check("top_no_extra_done_or_wrap", 32'(cnt), 32'd0);

        // Abort during bit 3 of byte 1 of window 0..3
        exp_q[0].push_back(8'h0F);
        exp_q[0].push_back(8'h22);
        pulse_start(0);
        repeat (58) @(posedge clk);
        #1 abort_v[0] = 1'b1;
        @(posedge clk);
        #1 abort_v[0] = 1'b0;
        run_until(0, 1'b0, 200, cyc, mx, mn, fl);
        check("abort_end_cycle", 32'(cyc), 32'd23);
        check("abort_no_done", 32'(done_v[0]), 32'd0);
        check("abort_max_addr", 32'(mx), 32'd1);
        check("abort_idle_addr", 32'(addr_v[0]), 32'd0);

        // start held through a dump, then re-issued in the done cycle
        for (int r = 0; r < 2; r++) begin
            exp_q[0].push_back(8'h0F); exp_q[0].push_back(8'h22);
            exp_q[0].push_back(8'h33); exp_q[0].push_back(8'h44);
        end
        @(posedge clk);
        #1 start_v[0] = 1'b1;
        repeat (100) @(posedge clk);
        #1 start_v[0] = 1'b0;
        check("b2b_busy_held", 32'(busy_v[0]), 32'd1);
        run_until(0, 1'b1, 300, cyc, mx, mn, fl);
        check("b2b_first_done", 32'(cyc), 32'd65);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        check("b2b_restart_busy", 32'(busy_v[0]), 32'd1);
        run_until(0, 1'b1, 300, cyc, mx, mn, fl);
        check("b2b_second_done", 32'(cyc), 32'd164);

        // Asynchronous reset during DATA bit 4 of byte 0
        pulse_start(0);
        repeat (22) @(posedge clk);
        #1;
        check("rst_mid_pre_tx", 32'(tx_v[0]), 32'd0);
        rst_v[0] = 1'b0;
        #1;
        check("rst_mid_tx", 32'(tx_v[0]), 32'd1);
        check("rst_mid_busy", 32'(busy_v[0]), 32'd0);
        check("rst_mid_addr", 32'(addr_v[0]), 32'd0);
        repeat (6) @(posedge clk);
        #1 rst_v[0] = 1'b1;
        low_cnt = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (!tx_v[0] || busy_v[0]) low_cnt++;
        end
        check("rst_mid_stays_idle", 32'(low_cnt), 32'd0);

        // Full 512-byte window at BAUD_DIV=2
        for (int i = 0; i < 512; i++) exp_q[3].push_back(rom[i]);
        pulse_start(3);
        run_until(3, 1'b1, 20000, cyc, mx, mn, fl);
        check("full_done_latency", 32'(cyc), 32'd10752);

        repeat (30) @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("queue_drained[%0d]", k), 32'(exp_q[k].size()), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
